// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

    localparam int BAUD_COUNT_DEFAULT = 868;
    localparam int DATA_BITS_DEFAULT  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_recv_if.sv
// rtl/uart_recv_if.sv - received-byte result bundle from the UART receiver
interface uart_recv_if;
    import uart_pkg::*;

    logic [DATA_BITS_DEFAULT-1:0] rx_data;
    logic                         rx_valid;
    logic                         rx_frame_err;
    logic                         rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer, resets to the idle-high line level
module uart_sync #(
    parameter int WIDTH = 1
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            meta     <= '1;
            sync_out <= '1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - 8N1 UART receiver sampling mid-bit from a start-edge counter
module uart_recv
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = BAUD_COUNT_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        UART_TXD_IN,
    uart_recv_if.master rx
);

    localparam int CNT_W = $clog2(BAUD_COUNT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_COUNT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    uart_sync #(.WIDTH(1)) u_sync (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .async_in   (UART_TXD_IN),
        .sync_out   (rxs)
    );

    assign rx.rx_busy = (state != ST_IDLE);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            rx.rx_data      <= '0;
            rx.rx_valid     <= 1'b0;
            rx.rx_frame_err <= 1'b0;
        end else begin
            rx.rx_valid     <= 1'b0;
            rx.rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rxs == START_BIT) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    // A start bit must still be low at its midpoint, else it was a glitch
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= (rxs == START_BIT) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rxs;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs == STOP_BIT) begin
                            rx.rx_data  <= shift_reg;
                            rx.rx_valid <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            rx.rx_frame_err <= 1'b1;
                            state           <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line must not be mistaken for a new start bit
                    cnt <= '0;
                    if (rxs == STOP_BIT) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - directed self-checking bench for uart_recv
module tb_uart_recv;

    logic CLK100MHZ  = 1'b0;
    logic CPU_RESETN = 1'b0;
    logic UART_TXD_IN = 1'b1;

    uart_recv_if rx_if ();

    uart_recv #(.BAUD_COUNT(868), .DATA_BITS(8)) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .UART_TXD_IN (UART_TXD_IN),
        .rx          (rx_if)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int cyc = 0;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    logic [7:0] vq_data[$];
    int         vq_cyc[$];
    int         err_cnt  = 0;
    int         both_cnt = 0;
    int         fall_cyc = 0;

    always @(negedge CLK100MHZ) begin
        if (rx_if.rx_valid) begin
            vq_data.push_back(rx_if.rx_data);
            vq_cyc.push_back(cyc);
        end
        if (rx_if.rx_frame_err) err_cnt++;
        if (rx_if.rx_valid && rx_if.rx_frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    // stop_low: hold the stop bit low for three bit times instead of sending it high
    task automatic send_frame(input logic [7:0] d, input int per, input bit stop_low);
        fall_cyc = cyc;
        UART_TXD_IN = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            UART_TXD_IN = d[i];
            tick(per);
        end
        if (stop_low) begin
            UART_TXD_IN = 1'b0;
            tick(3 * per);
        end else begin
            UART_TXD_IN = 1'b1;
            tick(per);
        end
    endtask

    task automatic wait_valid(input int n);
        for (int i = 0; i < 2000 && vq_data.size() < n; i++) tick(1);
        check("valid_count", vq_data.size(), n);
    endtask

    task automatic clear_q();
        vq_data.delete();
        vq_cyc.delete();
    endtask

    int lat;
    int err_before;

    initial begin
        tick(5);
        check("rst_data",  rx_if.rx_data, 8'h00);
        check("rst_valid", rx_if.rx_valid, 0);
        check("rst_err",   rx_if.rx_frame_err, 0);
        check("rst_busy",  rx_if.rx_busy, 0);
        CPU_RESETN = 1'b1;
        tick(20);

        // single frame, latency from start edge
        send_frame(8'hAF, 868, 1'b0);
        wait_valid(1);
        if (vq_data.size() >= 1) begin
            check("af_data", vq_data[0], 8'hAF);
            lat = vq_cyc[0] - fall_cyc;
            check("af_latency_window", (lat >= 8245 && lat <= 8249), 1);
        end
        check("af_no_err", err_cnt, 0);
        clear_q();

        // back-to-back frames with no idle gap
        send_frame(8'h00, 868, 1'b0);
        send_frame(8'hFF, 868, 1'b0);
        send_frame(8'h55, 868, 1'b0);
        wait_valid(3);
        if (vq_data.size() >= 3) begin
            check("b2b_data0", vq_data[0], 8'h00);
            check("b2b_data1", vq_data[1], 8'hFF);
            check("b2b_data2", vq_data[2], 8'h55);
            check("b2b_gap01", vq_cyc[1] - vq_cyc[0], 8680);
            check("b2b_gap12", vq_cyc[2] - vq_cyc[1], 8680);
        end
        clear_q();
        tick(10);

        // 200-cycle glitch on idle line
        fall_cyc = cyc;
        UART_TXD_IN = 1'b0;
        tick(200);
        UART_TXD_IN = 1'b1;
        for (int i = 0; i < 1000 && rx_if.rx_busy; i++) tick(1);
        lat = cyc - fall_cyc;
        check("glitch_idle_window", (lat >= 434 && lat <= 438), 1);
        tick(300);
        check("glitch_no_valid", vq_data.size(), 0);
        check("glitch_no_err", err_cnt, 0);
        check("glitch_data_kept", rx_if.rx_data, 8'h55);

        // framing error with line held low
        send_frame(8'h3C, 868, 1'b1);
        check("ferr_pulse", err_cnt, 1);
        check("ferr_no_valid", vq_data.size(), 0);
        check("ferr_data_kept", rx_if.rx_data, 8'h55);
        check("ferr_busy_low_line", rx_if.rx_busy, 1);
        UART_TXD_IN = 1'b1;
        tick(10);
        check("ferr_busy_release", rx_if.rx_busy, 0);
        send_frame(8'h81, 868, 1'b0);
        wait_valid(1);
        if (vq_data.size() >= 1) check("after_ferr_data", vq_data[0], 8'h81);
        clear_q();
        tick(10);

        // reset in the middle of data bit 4 of 0xA5
        err_before = err_cnt;
        UART_TXD_IN = 1'b0;
        tick(868);
        for (int i = 0; i < 4; i++) begin
            UART_TXD_IN = ((8'hA5 >> i) & 8'h01) != 0;
            tick(868);
        end
        UART_TXD_IN = 1'b0;
        tick(434);
        check("pre_rst_busy", rx_if.rx_busy, 1);
        CPU_RESETN = 1'b0;
        #1;
        check("mid_rst_data",  rx_if.rx_data, 8'h00);
        check("mid_rst_valid", rx_if.rx_valid, 0);
        check("mid_rst_err",   rx_if.rx_frame_err, 0);
        check("mid_rst_busy",  rx_if.rx_busy, 0);
        tick(5);
        UART_TXD_IN = 1'b1;
        tick(5);
        CPU_RESETN = 1'b1;
        tick(100);
        check("rst_abandon_no_valid", vq_data.size(), 0);
        check("rst_abandon_no_err", err_cnt, err_before);
        check("rst_abandon_idle", rx_if.rx_busy, 0);
        send_frame(8'h5A, 868, 1'b0);
        wait_valid(1);
        if (vq_data.size() >= 1) check("after_rst_data", vq_data[0], 8'h5A);
        clear_q();
        tick(10);

        // bit-rate tolerance
        send_frame(8'hC3, 851, 1'b0);
        wait_valid(1);
        if (vq_data.size() >= 1) check("fast_baud_data", vq_data[0], 8'hC3);
        clear_q();
        tick(10);
        send_frame(8'hC3, 885, 1'b0);
        wait_valid(1);
        if (vq_data.size() >= 1) check("slow_baud_data", vq_data[0], 8'hC3);
        clear_q();
        tick(10);

        check("total_err_pulses", err_cnt, 1);
        check("valid_err_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter BAUD_COUNT, default 868, gives clocks per bit (100 MHz / 115200 baud).
REQ-002 Parameter DATA_BITS, default 8, gives data bits per frame; only 8 needs to be supported.
REQ-003 CLK100MHZ  input  1  sole clock; all logic on its rising edge.
REQ-004 CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-005 UART_TXD_IN  input  1  serial line, asynchronous to CLK100MHZ, idle high.
REQ-006 rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-007 rx_valid  output  1  one-cycle pulse, rx_data newly updated.
REQ-008 rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 rx_busy  output  1  high whenever state is not IDLE.

Function
REQ-010 UART_TXD_IN shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 States: IDLE, START, DATA, STOP, WAIT_HIGH; one-hot or binary encoding is allowed.
REQ-013 In IDLE, rxs low shall move to START with the bit counter cleared.
REQ-014 In START, at counter == BAUD_COUNT/2-1 (433), rxs is sampled; low -> DATA with counter and bit index cleared; high -> IDLE (glitch rejected, no output pulse).
REQ-015 In DATA, the counter runs 0..BAUD_COUNT-1; at BAUD_COUNT-1, rxs shifts into shift_reg[bit_idx] and bit_idx increments; after bit 7 -> STOP.
REQ-016 In STOP, at counter == BAUD_COUNT-1: rxs high -> rx_data <= shift_reg, rx_valid = 1 for one cycle, -> IDLE.
REQ-017 In STOP, rxs low -> rx_frame_err = 1 for one cycle, rx_data unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH shall remain until rxs is high (break/line-low tolerant), then -> IDLE; a falling edge is not detected until IDLE.
REQ-019 Back-to-back frames (start bit immediately after stop sample) shall be received without loss.
REQ-020 rx_valid and rx_frame_err shall never assert in the same cycle.
REQ-021 Latency: rx_valid rises 2 + 433 + 9*868 = 8247 cycles (+/-2) after the UART_TXD_IN falling edge of the start bit.
REQ-022 The counter shall be $clog2(BAUD_COUNT) bits wide (10 at default) and shall never exceed BAUD_COUNT-1.

Reset
REQ-023 CPU_RESETN low shall immediately force: state IDLE; counter 0; bit_idx 0; shift_reg 0; rx_data 0x00; rx_valid 0; rx_frame_err 0; rx_busy 0; synchronizer flops 1.
REQ-024 Reset mid-frame shall abandon the frame with no pulse; after release the receiver waits in IDLE for a fresh falling edge.

Structure
REQ-025 Package uart_pkg shall hold the state encoding, BAUD_COUNT default, and frame-width constants, shared with the transmitter.
REQ-026 The synchronizer shall be sub-module uart_sync (2 flops, reset value 1, parameterised width 1).
REQ-027 The receiver shall have no other sub-modules; the expected size is 120-250 lines of RTL.

Verification
REQ-028 Drive frame 0xAF at 868 clk/bit -> one rx_valid pulse, rx_data = 0xAF at cycle 8247+/-2, rx_frame_err stays 0.
REQ-029 Drive 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three rx_valid pulses 8680 cycles apart, data in order.
REQ-030 Drive a 200-cycle low glitch on an idle line -> return to IDLE at about 436 cycles, no pulses, rx_data unchanged.
REQ-031 Drive 0x3C with the stop bit held low for 3 bit times -> rx_frame_err pulse, rx_data keeps previous value, rx_busy high until the line returns high, next frame 0x81 received correctly.
REQ-032 Assert CPU_RESETN low during data bit 4 of 0xA5 -> outputs at reset values at once; next full frame 0x5A received correctly.
REQ-033 Drive a bit period of 868 +/- 2% (851 and 885 clk/bit) for 0xC3 -> rx_data = 0xC3 in both cases.
